// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants, scan state type and hex-to-segment table.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Active-low {g,f,e,d,c,b,a} patterns for a common-anode digit
   function automatic logic [6:0] hex2seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module   : seg7_hex_decode
// Purpose  : Combinational hex nibble to active-low 7-segment pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = hex2seg(i_hex);

endmodule

`default_nettype wire

// File: rtl/seg7_hist_scan.sv
// ============================================================================
// Module   : seg7_hist_scan
// Purpose  : History of the last N_DIGITS distinct counter values, scanned
//            onto a multiplexed common-anode 7-segment display.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_hist_scan
   import seg7_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 1
)(
   input  logic                CLK,
   input  logic                XRST,
   input  logic [3:0]          Q,
   input  logic                FREEZE,
   output logic [6:0]          SEG,
   output logic                DP,
   output logic [N_DIGITS-1:0] AN,
   output logic                CHG
);

   localparam int c_cnt_max = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
   localparam int c_dig_w   = $clog2(N_DIGITS);

   localparam logic [c_cnt_w-1:0]  c_scan_last  = c_cnt_w'(SCAN_DIV - 1);
   localparam logic [c_cnt_w-1:0]  c_blank_last = c_cnt_w'(BLANK_CYC - 1);
   localparam logic [c_dig_w-1:0]  c_digit_last = c_dig_w'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] c_an_one     = {{(N_DIGITS-1){1'b0}}, 1'b1};

   logic [3:0]          r_q_s;
   logic                r_q_s_vld;
   logic [3:0]          r_q_last;
   logic                r_primed;
   logic [3:0]          r_hist [N_DIGITS];
   logic [N_DIGITS-1:0] r_valid;
   logic                r_chg;
   logic                w_capture;

   scan_state_t         r_state, w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
   logic [c_dig_w-1:0]  r_digit, w_digit_nxt;

   logic [3:0]          w_digit_val;
   logic [6:0]          w_seg_dec;
   logic [6:0]          r_seg, w_seg_nxt;
   logic                r_dp, w_dp_nxt;
   logic [N_DIGITS-1:0] r_an, w_an_nxt;

   // r_q_s_vld holds off capture until q_s carries a real sample of Q
   assign w_capture = r_q_s_vld & ~FREEZE & (~r_primed | (r_q_s != r_q_last));

   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         r_q_s     <= '0;
         r_q_s_vld <= 1'b0;
         r_q_last  <= '0;
         r_primed  <= 1'b0;
         r_valid   <= '0;
         r_chg     <= 1'b0;
         for (int i = 0; i < N_DIGITS; i++) begin
            r_hist[i] <= '0;
         end
      end else begin
         r_q_s     <= Q;
         r_q_s_vld <= 1'b1;
         r_q_last  <= r_q_s;
         r_chg     <= w_capture;
         if (w_capture) begin
            r_primed  <= 1'b1;
            r_hist[0] <= r_q_s;
            for (int i = 1; i < N_DIGITS; i++) begin
               r_hist[i] <= r_hist[i-1];
            end
            r_valid <= {r_valid[N_DIGITS-2:0], 1'b1};
         end
      end
   end

   assign w_digit_val = r_hist[r_digit];

   seg7_hex_decode u_dec (
      .i_hex (w_digit_val),
      .o_seg (w_seg_dec)
   );

   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         r_state <= BLANK;
         r_cnt   <= '0;
         r_digit <= '0;
         r_seg   <= SEG_BLANK;
         r_dp    <= 1'b1;
         r_an    <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_digit <= w_digit_nxt;
         r_seg   <= w_seg_nxt;
         r_dp    <= w_dp_nxt;
         r_an    <= w_an_nxt;
      end
   end

   // Outputs register the current slot, so a history shift reaches SEG one edge later
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_digit_nxt = r_digit;
      w_an_nxt    = '1;
      w_seg_nxt   = SEG_BLANK;
      w_dp_nxt    = 1'b1;
      case (r_state)
         BLANK: begin
            if (r_cnt == c_blank_last) begin
               w_state_nxt = DRIVE;
               w_cnt_nxt   = '0;
            end
         end
         DRIVE: begin
            w_an_nxt  = ~(c_an_one << r_digit);
            w_seg_nxt = r_valid[r_digit] ? w_seg_dec : SEG_BLANK;
            w_dp_nxt  = (r_digit != '0);
            if (r_cnt == c_scan_last) begin
               w_state_nxt = BLANK;
               w_cnt_nxt   = '0;
               w_digit_nxt = (r_digit == c_digit_last) ? '0 : r_digit + 1'b1;
            end
         end
         default: begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign SEG = r_seg;
   assign DP  = r_dp;
   assign AN  = r_an;
   assign CHG = r_chg;

endmodule

`default_nettype wire

// File: tb/tb_seg7_hist_scan.sv
// ============================================================================
// Module   : tb_seg7_hist_scan
// Purpose  : Self-checking bench for seg7_hist_scan (4 digits, 4/1 scan).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_hist_scan;
   import seg7_pkg::*;

   localparam int N = 4;

   typedef logic [N-1:0][6:0] digits_t;
   typedef struct {
      logic [3:0] q;
      logic       freeze;
      logic       chg;
      digits_t    exp;
   } vec_t;

   logic          CLK;
   logic          XRST;
   logic [3:0]    Q;
   logic          FREEZE;
   logic [6:0]    SEG;
   logic          DP;
   logic [N-1:0]  AN;
   logic          CHG;

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int chg_total = 0;
   int exp_total = 0;
   int chg_q [$];
   vec_t vecs [11];

   seg7_hist_scan #(
      .N_DIGITS  (N),
      .SCAN_DIV  (4),
      .BLANK_CYC (1)
   ) dut (
      .CLK    (CLK),
      .XRST   (XRST),
      .Q      (Q),
      .FREEZE (FREEZE),
      .SEG    (SEG),
      .DP     (DP),
      .AN     (AN),
      .CHG    (CHG)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic digits_t mk(input logic [6:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // CHG scoreboard: each expected pulse cycle is queued when its stimulus is driven
   always @(negedge CLK) begin
      while (chg_q.size() > 0 && chg_q[0] < cyc) begin
         n_checks++;
         n_errors++;
         $display("FAIL chg_missing: no CHG at cycle %0d (now %0d)", chg_q[0], cyc);
         void'(chg_q.pop_front());
      end
      if (CHG === 1'b1) begin
         chg_total++;
         n_checks++;
         if (chg_q.size() > 0 && chg_q[0] == cyc) begin
            void'(chg_q.pop_front());
         end else begin
            n_errors++;
            $display("FAIL chg_unexpected: CHG=1 at cycle %0d, next expected %0d",
                     cyc, (chg_q.size() > 0) ? chg_q[0] : -1);
         end
      end
   end

   task automatic wait_an(input logic [N-1:0] target, input string tag);
      int g;
      g = 0;
      while (AN !== target && g < 100) begin
         @(negedge CLK);
         g++;
      end
      if (AN !== target) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_wait_an: AN=%b never reached %b", tag, AN, target);
      end
   endtask

   // Capture one full frame starting at the digit-0 slot and compare every slot
   task automatic check_frame(input digits_t exp, input string tag);
      logic [6:0] seen_seg [N];
      bit         seen [N];
      bit         blank_ok, dp_ok, stable, an_ok, found;
      blank_ok = 1'b1;
      dp_ok    = 1'b1;
      stable   = 1'b1;
      an_ok    = 1'b1;
      for (int d = 0; d < N; d++) begin
         seen[d]     = 1'b0;
         seen_seg[d] = '0;
      end
      repeat (8) @(negedge CLK);
      wait_an('1, tag);
      wait_an(~N'(1), tag);
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge CLK);
         if (AN === '1) begin
            if (SEG !== SEG_BLANK || DP !== 1'b1) blank_ok = 1'b0;
         end else begin
            found = 1'b0;
            for (int d = 0; d < N; d++) begin
               if (AN === ~(N'(1) << d)) begin
                  found = 1'b1;
                  if (!seen[d]) begin
                     seen[d]     = 1'b1;
                     seen_seg[d] = SEG;
                  end else if (SEG !== seen_seg[d]) begin
                     stable = 1'b0;
                  end
                  if (DP !== ((d == 0) ? 1'b0 : 1'b1)) dp_ok = 1'b0;
               end
            end
            if (!found) an_ok = 1'b0;
         end
      end
      for (int d = 0; d < N; d++) begin
         chk($sformatf("%s_digit%0d", tag, d),
             seen[d] ? {25'd0, seen_seg[d]} : 32'hFFFF_FFFF, {25'd0, exp[d]});
      end
      chk({tag, "_blank_slot"}, {31'd0, blank_ok}, 32'd1);
      chk({tag, "_dp"},         {31'd0, dp_ok},    32'd1);
      chk({tag, "_stable"},     {31'd0, stable},   32'd1);
      chk({tag, "_an_onehot"},  {31'd0, an_ok},    32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit         hold_ok;
      int         g, s, k;
      logic [3:0] e;

      vecs[0]  = '{4'h1, 1'b0, 1'b1, mk(7'h79, 7'h40, 7'h7F, 7'h7F)};
      vecs[1]  = '{4'h2, 1'b0, 1'b1, mk(7'h24, 7'h79, 7'h40, 7'h7F)};
      vecs[2]  = '{4'h3, 1'b0, 1'b1, mk(7'h30, 7'h24, 7'h79, 7'h40)};
      vecs[3]  = '{4'hE, 1'b0, 1'b1, mk(7'h06, 7'h30, 7'h24, 7'h79)};
      vecs[4]  = '{4'hF, 1'b0, 1'b1, mk(7'h0E, 7'h06, 7'h30, 7'h24)};
      vecs[5]  = '{4'h0, 1'b0, 1'b1, mk(7'h40, 7'h0E, 7'h06, 7'h30)};
      vecs[6]  = '{4'h5, 1'b0, 1'b1, mk(7'h12, 7'h40, 7'h0E, 7'h06)};
      vecs[7]  = '{4'h5, 1'b1, 1'b0, mk(7'h12, 7'h40, 7'h0E, 7'h06)};
      vecs[8]  = '{4'h9, 1'b1, 1'b0, mk(7'h12, 7'h40, 7'h0E, 7'h06)};
      vecs[9]  = '{4'h9, 1'b0, 1'b0, mk(7'h12, 7'h40, 7'h0E, 7'h06)};
      vecs[10] = '{4'hA, 1'b0, 1'b1, mk(7'h08, 7'h12, 7'h40, 7'h0E)};

      XRST   = 1'b1;
      Q      = 4'h0;
      FREEZE = 1'b0;
      #2 XRST = 1'b0;
      #1;
      chk("rst_seg", {25'd0, SEG}, 32'h7F);
      chk("rst_an",  {28'd0, AN},  32'hF);
      chk("rst_dp",  {31'd0, DP},  32'd1);
      chk("rst_chg", {31'd0, CHG}, 32'd0);
      repeat (3) @(negedge CLK);

      // First sample after reset is captured even though Q=0
      @(negedge CLK);
      XRST = 1'b1;
      chg_q.push_back(cyc + 2);
      exp_total = 1;
      check_frame(mk(7'h40, 7'h7F, 7'h7F, 7'h7F), "primed");
      chk("primed_chg_total", chg_total, exp_total);

      for (int i = 0; i < 11; i++) begin
         @(negedge CLK);
         Q      = vecs[i].q;
         FREEZE = vecs[i].freeze;
         if (vecs[i].chg) begin
            chg_q.push_back(cyc + 2);
            exp_total++;
         end
         check_frame(vecs[i].exp, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_chg_total", i), chg_total, exp_total);
      end

      // Asynchronous reset in the middle of a DRIVE slot
      g = 0;
      @(negedge CLK);
      while (AN === 4'hF && g < 50) begin
         @(negedge CLK);
         g++;
      end
      chk("midrst_in_drive", {31'd0, (AN !== 4'hF)}, 32'd1);
      #2 XRST = 1'b0;
      #1;
      chk("midrst_seg", {25'd0, SEG}, 32'h7F);
      chk("midrst_an",  {28'd0, AN},  32'hF);
      chk("midrst_dp",  {31'd0, DP},  32'd1);
      chk("midrst_chg", {31'd0, CHG}, 32'd0);
      hold_ok = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         if (SEG !== 7'h7F || AN !== 4'hF || DP !== 1'b1 || CHG !== 1'b0) hold_ok = 1'b0;
      end
      chk("midrst_hold", {31'd0, hold_ok}, 32'd1);

      @(negedge CLK);
      XRST = 1'b1;
      chg_q.push_back(cyc + 2);
      exp_total++;
      check_frame(mk(7'h08, 7'h7F, 7'h7F, 7'h7F), "rerst");
      chk("rerst_chg_total", chg_total, exp_total);

      // Scan sequence over two frame periods, starting at the blank before digit 0
      wait_an(4'h7, "timing");
      wait_an(4'hF, "timing");
      for (int i = 0; i < 40; i++) begin
         s = (i % 20) / 5;
         k = (i % 20) % 5;
         e = (k == 0) ? 4'hF : ~(4'(1) << s);
         if (i > 0) @(negedge CLK);
         chk($sformatf("an_seq%0d", i), {28'd0, AN}, {28'd0, e});
      end

      repeat (4) @(negedge CLK);
      chk("chg_queue_empty", chg_q.size(), 0);
      chk("final_chg_total", chg_total, exp_total);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
